// File: rtl/clk_div_ctrl.sv
// Runtime-programmable clock divider with glitch-free ratio changes and EN start/stop.
// Optional macro DIV_LOCK_CNT_EN: STABLE also waits for LOCK_CYC divided periods after each (re)start.
module clk_div_ctrl #(
  parameter int CNT_W        = 5,
  parameter int DEFAULT_HALF = 8,
  parameter int LOCK_CYC     = 2
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             EN,
  input  logic             CFG_VALID,
  input  logic [CNT_W-1:0] CFG_HALF,
  output logic             CFG_READY,
  output logic             CLK_DIV,
  output logic             DIV_TICK,
  output logic             STABLE,
  output logic             BUSY
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PEND = 2'd2,
    S_STOP = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEF_HALF = CNT_W'(DEFAULT_HALF);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             stop_req_q, stop_req_d;
  logic             clk_div_q, clk_div_d;
  logic             tick_q, tick_d;
  logic             xfer;
  logic             bound;
  logic             fall_edge;
  logic             enter_run;
  logic             apply;

  function automatic logic [CNT_W-1:0] clamp_half(input logic [CNT_W-1:0] h);
    return (h == '0) ? ONE : h;
  endfunction

  assign CFG_READY = (state_q == S_IDLE) || (state_q == S_RUN);
  assign xfer      = CFG_VALID && CFG_READY;
  assign bound     = (cnt_q == half_q);
  assign fall_edge = bound && clk_div_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    half_d     = half_q;
    pend_d     = pend_q;
    stop_req_d = stop_req_q;
    clk_div_d  = clk_div_q;
    tick_d     = 1'b0;
    enter_run  = 1'b0;
    apply      = 1'b0;

    // Compare before increment, so cnt never exceeds half and cannot wrap.
    if (state_q != S_IDLE) begin
      if (bound) begin
        clk_div_d = ~clk_div_q;
        cnt_d     = ONE;
        tick_d    = ~clk_div_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        clk_div_d = 1'b0;
        cnt_d     = ONE;
        if (xfer) begin
          half_d = clamp_half(CFG_HALF);
        end
        if (EN) begin
          state_d   = S_RUN;
          enter_run = 1'b1;
        end
      end
      S_RUN: begin
        if (xfer) begin
          pend_d     = clamp_half(CFG_HALF);
          stop_req_d = ~EN;
          state_d    = S_PEND;
        end else if (!EN) begin
          state_d = S_STOP;
        end
      end
      S_PEND: begin
        // New ratio takes over only where CLK_DIV falls, so no short pulse escapes.
        if (fall_edge) begin
          apply      = 1'b1;
          half_d     = pend_q;
          stop_req_d = 1'b0;
          state_d    = (stop_req_q || !EN) ? S_IDLE : S_RUN;
        end
      end
      S_STOP: begin
        if (!clk_div_q) begin
          clk_div_d = 1'b0;
          cnt_d     = ONE;
          tick_d    = 1'b0;
          state_d   = S_IDLE;
        end else if (bound) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q    <= S_IDLE;
      cnt_q      <= ONE;
      half_q     <= DEF_HALF;
      pend_q     <= '0;
      stop_req_q <= 1'b0;
      clk_div_q  <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      half_q     <= half_d;
      pend_q     <= pend_d;
      stop_req_q <= stop_req_d;
      clk_div_q  <= clk_div_d;
      tick_q     <= tick_d;
    end
  end

  assign CLK_DIV  = clk_div_q;
  assign DIV_TICK = tick_q;
  assign BUSY     = (state_q != S_IDLE);

`ifdef DIV_LOCK_CNT_EN
  localparam int              LOCK_W   = $clog2(LOCK_CYC + 1) + 1;
  localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_CYC);

  logic [LOCK_W-1:0] lock_q, lock_d;

  // Counts completed rising edges of the current ratio, saturating at LOCK_MAX.
  always_comb begin
    lock_d = lock_q;
    if (enter_run || apply) begin
      lock_d = '0;
    end else if (tick_q && (lock_q != LOCK_MAX)) begin
      lock_d = lock_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      lock_q <= '0;
    end else begin
      lock_q <= lock_d;
    end
  end

  assign STABLE = (state_q == S_RUN) && (lock_q >= LOCK_MAX);
`else
  logic unused_lock;
  assign unused_lock = enter_run ^ apply ^ (LOCK_CYC > 0);
  assign STABLE      = (state_q == S_RUN);
`endif

endmodule
